// File: rtl/two_one_mux_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | two_one_mux_arbiter_pkg                                              |
// | State encodings and requester IDs shared by the mux arbiter.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package two_one_mux_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT_A = 2'b01,
    ST_GRANT_B = 2'b10
  } state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/two_one_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | two_one_mux                                                          |
// | Behavioral 1-bit 2:1 data select (S = 0 picks A, S = 1 picks B).     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module two_one_mux (
  input  logic A,
  input  logic B,
  input  logic S,
  output logic Y
);

  assign Y = S ? B : A;

endmodule
`default_nettype wire

// File: rtl/two_one_mux_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | two_one_mux_arbiter                                                  |
// | Round-robin arbiter with hold limit driving a shared 1-bit 2:1 mux.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module two_one_mux_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic Clk,
  input  logic Rst,
  input  logic ReqA,
  input  logic ReqB,
  input  logic A,
  input  logic B,
  output logic GntA,
  output logic GntB,
  output logic S,
  output logic Y,
  output logic Valid
);

  import two_one_mux_arbiter_pkg::*;

  localparam logic [CNT_W-1:0] c_hold_max = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic             r_y;
  logic             r_valid;
  logic             w_mux_y;
  logic             w_xfer;

  always_comb begin
    w_state_nxt = ST_IDLE;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;

    case (r_state)
      ST_IDLE: begin
        if (ReqA && ReqB)
          w_state_nxt = (r_last == ID_A) ? ST_GRANT_B : ST_GRANT_A;
        else if (ReqA)
          w_state_nxt = ST_GRANT_A;
        else if (ReqB)
          w_state_nxt = ST_GRANT_B;
        else
          w_state_nxt = ST_IDLE;
      end
      ST_GRANT_A: begin
        if (!ReqA)
          w_state_nxt = ReqB ? ST_GRANT_B : ST_IDLE;
        else if (ReqB && (r_cnt == c_hold_max))
          w_state_nxt = ST_GRANT_B;
        else
          w_state_nxt = ST_GRANT_A;
      end
      ST_GRANT_B: begin
        if (!ReqB)
          w_state_nxt = ReqA ? ST_GRANT_A : ST_IDLE;
        else if (ReqA && (r_cnt == c_hold_max))
          w_state_nxt = ST_GRANT_A;
        else
          w_state_nxt = ST_GRANT_B;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Entering a grant restarts the hold window; staying extends it.
    if ((w_state_nxt != r_state) && (w_state_nxt != ST_IDLE)) begin
      w_cnt_nxt  = '0;
      w_last_nxt = (w_state_nxt == ST_GRANT_B) ? ID_B : ID_A;
    end else if ((w_state_nxt != ST_IDLE) && (r_cnt != c_hold_max)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  assign GntA   = (r_state == ST_GRANT_A);
  assign GntB   = (r_state == ST_GRANT_B);
  assign S      = GntB;
  assign w_xfer = (GntA & ReqA) | (GntB & ReqB);
  assign Y      = r_y;
  assign Valid  = r_valid;

  two_one_mux u_mux (
    .A (A),
    .B (B),
    .S (S),
    .Y (w_mux_y)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= ID_B;
      r_y     <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_valid <= w_xfer;
      if (w_xfer)
        r_y <= w_mux_y;
    end
  end

endmodule
`default_nettype wire

// File: doc/two_one_mux_arbiter.md
Name: two_one_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 1-bit 2:1 mux datapath.
- Two requesters (A, B) compete for the path. The arbiter drives the mux select S, grants one requester at a time and registers the selected bit onto Y with a Valid qualifier.
- A granted requester keeps the path for up to MAX_HOLD consecutive cycles while the other is waiting.
- Sits between the two data sources and the downstream single-bit consumer.

Parameters:
- MAX_HOLD, 4, max consecutive grant cycles for one requester while the other requests; legal range 1..255.
- CNT_W, 8, width of the hold counter; must hold MAX_HOLD-1.

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous active-high reset
- ReqA  input  1  requester A has a data bit to send this cycle
- ReqB  input  1  requester B has a data bit to send this cycle
- A  input  1  data bit from requester A
- B  input  1  data bit from requester B
- GntA  output  1  registered; A owns the path this cycle
- GntB  output  1  registered; B owns the path this cycle
- S  output  1  mux select (0 = A, 1 = B); equals GntB
- Y  output  1  registered muxed data bit
- Valid  output  1  Y holds a transferred bit this cycle

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, including mid-grant):
  - state = IDLE; GntA = GntB = S = 0; Y = 0; Valid = 0; hold count = 0.
  - Last = B, so A wins the first tie.
- States: IDLE (00), GRANT_A (01), GRANT_B (10). Encoding 11 is illegal and recovers to IDLE next cycle.
- GntA = (state == GRANT_A); GntB = S = (state == GRANT_B). GntA and GntB are never both 1.
- IDLE:
  - ReqA and ReqB both 1 → grant the requester that is not Last.
  - Only one request → grant that requester.
  - No request → stay in IDLE.
- GRANT_X (Y = the other requester):
  - ReqX = 0 → go to GRANT_Y if ReqY = 1, else IDLE.
  - ReqX = 1, ReqY = 1, count == MAX_HOLD-1 → go to GRANT_Y (forced rotation).
  - Otherwise stay in GRANT_X and increment count, saturating at MAX_HOLD-1.
  - A lone requester holds the path indefinitely.
- Hold count and Last:
  - On every entry to a grant state: count = 0 and Last = new owner.
  - A direct switch GRANT_A ↔ GRANT_B is legal and inserts no bubble cycle.
- Transfer handshake:
  - A bit transfers on a cycle where GntX = 1 and ReqX = 1; the requester holds X stable during that cycle.
  - Next edge: Y <= (S ? B : A) and Valid <= (GntA & ReqA) | (GntB & ReqB). Latency is 1 cycle from the transfer cycle to Y/Valid.
  - When no transfer occurs, Valid = 0 and Y keeps its previous value.
- Request drop: if a request drops while it is granted, no transfer occurs that cycle (Valid = 0 next cycle).
- Requests are sampled each cycle; a requester never sees a grant it did not request in the previous state evaluation.
- MAX_HOLD = 1: with both requesting continuously, grants alternate every cycle.

Decomposition:
- Shared package/include file holds:
  - State encodings: ST_IDLE = 2'b00, ST_GRANT_A = 2'b01, ST_GRANT_B = 2'b10.
  - Requester IDs: ID_A = 0, ID_B = 1 (used for Last).
- Instantiate the existing behavioral two_one_mux as the data-select sub-module, driven by S, feeding the Y register.
- FSM, hold counter and output registers stay in this module.

Test Plan:
- Reset: assert Rst mid-grant asynchronously → GntA, GntB, S, Y, Valid all 0 before the next edge; after release with ReqA = ReqB = 1, the first grant is GntA.
- Single requester: ReqA = 1 for 10 cycles, A = 1,0,1,1,… → GntA stays 1 throughout; Y replays A one cycle late; Valid = 1 from the cycle after the first grant.
- Contention, MAX_HOLD = 4: ReqA = ReqB = 1 continuously → GntA for 4 cycles, GntB for 4, GntA for 4; no gap cycles; Valid stays 1.
- Early release: GRANT_A with count = 1, ReqA drops, ReqB = 1 → next cycle GntB = 1, count = 0; Valid = 0 for the dropped cycle.
- Idle return: in GRANT_B, ReqB → 0 with ReqA = 0 → IDLE; GntA = GntB = 0; Valid = 0 one cycle later; Y holds its last value.
- MAX_HOLD = 1 build: both requesting, A = 0, B = 1 → Y toggles 0,1,0,1 and S alternates each cycle.
